// File: rtl/match_controller.sv
// Round/match sequencer around the per-frame game logic datapath.
// Drives logic reset and step strobe, tracks health, timer and rounds.
module match_controller #(
    parameter int MAX_HEALTH     = 100,
    parameter int HIT_DAMAGE     = 10,
    parameter int HEALTH_DEPTH   = 7,
    parameter int ROUND_SECONDS  = 99,
    parameter int FRAMES_PER_SEC = 60,
    parameter int INTRO_FRAMES   = 120,
    parameter int OUTRO_FRAMES   = 180,
    parameter int ROUNDS_TO_WIN  = 2
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic                    frame_tick,
    input  logic                    start,
    input  logic                    logic_done,
    input  logic                    p1_hit,
    input  logic                    p2_hit,
    output logic                    logic_rst,
    output logic                    frame_step,
    output logic [2:0]              phase,
    output logic [HEALTH_DEPTH-1:0] p1_health,
    output logic [HEALTH_DEPTH-1:0] p2_health,
    output logic [6:0]              timer_sec,
    output logic [1:0]              p1_rounds,
    output logic [1:0]              p2_rounds,
    output logic [1:0]              round_winner,
    output logic [1:0]              match_winner,
    output logic [7:0]              overrun_cnt
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        INTRO      = 3'd1,
        FIGHT      = 3'd2,
        ROUND_END  = 3'd3,
        MATCH_OVER = 3'd4
    } phase_t;

    localparam logic [HEALTH_DEPTH-1:0] HP_MAX = HEALTH_DEPTH'(MAX_HEALTH);
    localparam logic [HEALTH_DEPTH-1:0] DMG    = HEALTH_DEPTH'(HIT_DAMAGE);
    localparam logic [6:0] SECS    = 7'(ROUND_SECONDS);
    localparam logic [7:0] FPS_N   = 8'(FRAMES_PER_SEC);
    localparam logic [7:0] INTRO_N = 8'(INTRO_FRAMES);
    localparam logic [7:0] OUTRO_N = 8'(OUTRO_FRAMES);
    localparam logic [1:0] WIN_N   = 2'(ROUNDS_TO_WIN);

    phase_t state;
    logic [7:0] tick_cnt;
    logic [7:0] fcnt;
    logic       busy;
    logic [1:0] age;

    logic                    done_now;
    logic [HEALTH_DEPTH-1:0] p1_next;
    logic [HEALTH_DEPTH-1:0] p2_next;
    logic [7:0]              fcnt_inc;
    logic                    sec_wrap;
    logic [6:0]              timer_next;
    logic                    round_over;

    assign phase = state;

    // Completion needs two full cycles after the step strobe.
    always_comb begin
        done_now   = busy && (age == 2'd2) && logic_done;
        p1_next    = p1_health;
        p2_next    = p2_health;
        if (p2_hit)
            p1_next = (p1_health < DMG) ? '0 : p1_health - DMG;
        if (p1_hit)
            p2_next = (p2_health < DMG) ? '0 : p2_health - DMG;
        fcnt_inc   = fcnt + 8'd1;
        sec_wrap   = (fcnt_inc == FPS_N);
        timer_next = timer_sec;
        if (sec_wrap && timer_sec != 7'd0)
            timer_next = timer_sec - 7'd1;
        round_over = (p1_next == '0) || (p2_next == '0)
                  || (timer_next == 7'd0);
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            logic_rst    <= 1'b1;
            frame_step   <= 1'b0;
            p1_health    <= HP_MAX;
            p2_health    <= HP_MAX;
            timer_sec    <= SECS;
            p1_rounds    <= 2'd0;
            p2_rounds    <= 2'd0;
            round_winner <= 2'b00;
            match_winner <= 2'b00;
            overrun_cnt  <= 8'd0;
            tick_cnt     <= 8'd0;
            fcnt         <= 8'd0;
            busy         <= 1'b0;
            age          <= 2'd0;
        end else begin
            frame_step <= 1'b0;
            if (start && (state == IDLE || state == MATCH_OVER)) begin
                state        <= INTRO;
                logic_rst    <= 1'b1;
                p1_rounds    <= 2'd0;
                p2_rounds    <= 2'd0;
                round_winner <= 2'b00;
                match_winner <= 2'b00;
                overrun_cnt  <= 8'd0;
                p1_health    <= HP_MAX;
                p2_health    <= HP_MAX;
                timer_sec    <= SECS;
                fcnt         <= 8'd0;
                tick_cnt     <= 8'd0;
                busy         <= 1'b0;
            end else begin
                case (state)
                    IDLE: logic_rst <= 1'b1;
                    INTRO: begin
                        if (frame_tick) begin
                            if (tick_cnt == INTRO_N - 8'd1) begin
                                state     <= FIGHT;
                                logic_rst <= 1'b0;
                                tick_cnt  <= 8'd0;
                            end else begin
                                tick_cnt <= tick_cnt + 8'd1;
                            end
                        end
                    end
                    FIGHT: begin
                        if (busy) begin
                            if (age != 2'd2)
                                age <= age + 2'd1;
                            if (frame_tick && overrun_cnt != 8'hFF)
                                overrun_cnt <= overrun_cnt + 8'd1;
                            if (done_now) begin
                                busy      <= 1'b0;
                                p1_health <= p1_next;
                                p2_health <= p2_next;
                                fcnt      <= sec_wrap ? 8'd0 : fcnt_inc;
                                timer_sec <= timer_next;
                                if (round_over) begin
                                    state    <= ROUND_END;
                                    tick_cnt <= 8'd0;
                                    if (p1_next > p2_next) begin
                                        round_winner <= 2'b01;
                                        p1_rounds    <= p1_rounds + 2'd1;
                                    end else if (p2_next > p1_next) begin
                                        round_winner <= 2'b10;
                                        p2_rounds    <= p2_rounds + 2'd1;
                                    end else begin
                                        round_winner <= 2'b00;
                                    end
                                end
                            end
                        end else if (frame_tick) begin
                            frame_step <= 1'b1;
                            busy       <= 1'b1;
                            age        <= 2'd0;
                        end
                    end
                    ROUND_END: begin
                        if (frame_tick) begin
                            if (tick_cnt == OUTRO_N - 8'd1) begin
                                tick_cnt <= 8'd0;
                                if (p1_rounds == WIN_N) begin
                                    state        <= MATCH_OVER;
                                    match_winner <= 2'b01;
                                end else if (p2_rounds == WIN_N) begin
                                    state        <= MATCH_OVER;
                                    match_winner <= 2'b10;
                                end else begin
                                    state     <= INTRO;
                                    logic_rst <= 1'b1;
                                    p1_health <= HP_MAX;
                                    p2_health <= HP_MAX;
                                    timer_sec <= SECS;
                                    fcnt      <= 8'd0;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + 8'd1;
                            end
                        end
                    end
                    MATCH_OVER: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Round/match sequencer wrapped around the per-frame game logic datapath (two player state calculators plus hit calculator).
- Owns the game logic reset and the per-frame step strobe, and waits on the datapath done handshake.
- Turns per-frame attack-connected flags into health, round timer, round wins and match winner for the renderer/HUD.

Parameters:
MAX_HEALTH, 100, starting health per player per round
HIT_DAMAGE, 10, health removed per connected attack
HEALTH_DEPTH, 7, health register width (must hold MAX_HEALTH)
ROUND_SECONDS, 99, round timer start value
FRAMES_PER_SEC, 60, completed frames per timer decrement
INTRO_FRAMES, 120, frame ticks spent in INTRO
OUTRO_FRAMES, 180, frame ticks spent in ROUND_END
ROUNDS_TO_WIN, 2, round wins that end the match

Ports:
sys_clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
frame_tick  in  1  one-cycle pulse per video frame, sys_clk domain
start  in  1  one-cycle pulse: start or restart match
logic_done  in  1  datapath done (AND of both players' done)
p1_hit  in  1  P1 attack connected this frame (damages P2)
p2_hit  in  1  P2 attack connected this frame (damages P1)
logic_rst  out  1  active-high reset to game logic
frame_step  out  1  one-cycle strobe: datapath computes next frame
phase  out  3  IDLE=0 INTRO=1 FIGHT=2 ROUND_END=3 MATCH_OVER=4
p1_health  out  HEALTH_DEPTH  P1 health
p2_health  out  HEALTH_DEPTH  P2 health
timer_sec  out  7  round seconds remaining
p1_rounds  out  2  P1 round wins
p2_rounds  out  2  P2 round wins
round_winner  out  2  last round result: 00 none/draw, 01 P1, 10 P2
match_winner  out  2  00 none, 01 P1, 10 P2
overrun_cnt  out  8  saturating count of frame ticks dropped while busy

Behaviour:
- Reset (rst=0, async): phase=IDLE, logic_rst=1, frame_step=0, healths=MAX_HEALTH, timer_sec=ROUND_SECONDS, rounds=0, round_winner=0, match_winner=0, overrun_cnt=0, busy=0, internal counters=0. Reset mid-operation aborts any outstanding step immediately.
- IDLE:
  - logic_rst=1.
  - start -> INTRO; clears rounds, winners and overrun_cnt.
- INTRO:
  - On entry: logic_rst=1, healths=MAX_HEALTH, timer_sec=ROUND_SECONDS, frame/sec counter=0.
  - Counts frame_tick. On the INTRO_FRAMES-th tick -> FIGHT; logic_rst=0 from the next cycle.
- FIGHT step handshake:
  - On frame_tick with busy=0: frame_step=1 for exactly the next cycle, and busy=1.
  - Completion is the first cycle, at least 2 cycles after the frame_step cycle, in which logic_done=1. On completion, busy=0.
  - frame_tick while busy=1: no step; overrun_cnt+1, saturating at 255.
- FIGHT completion-cycle update:
  - p1_hit and p2_hit are sampled only on the completion cycle.
  - p2_health -= HIT_DAMAGE if p1_hit; p1_health -= HIT_DAMAGE if p2_hit. Both may apply in the same cycle. Each health floors at 0 (no wrap).
  - Frame counter increments. When it reaches FRAMES_PER_SEC it resets to 0 and timer_sec decrements (floor 0).
- Round end:
  - Evaluated on the updated values in the same completion cycle.
  - Any health=0, or timer_sec=0 -> ROUND_END next cycle.
  - Winner rule, KO and timeout alike: higher health wins; equal health (including double KO) gives a draw (round_winner=00, no round awarded).
  - The winner's round counter increments on ROUND_END entry. round_winner holds until the next ROUND_END entry or start.
- ROUND_END:
  - logic_rst=0, no frame_step; the datapath freezes on the last frame.
  - Counts OUTRO_FRAMES ticks, then:
    - either rounds counter == ROUNDS_TO_WIN -> MATCH_OVER, match_winner set;
    - otherwise -> INTRO.
- MATCH_OVER:
  - Outputs held, no steps.
  - start -> INTRO with rounds, winners and overrun_cnt cleared.
- start outside IDLE/MATCH_OVER is ignored.
- frame_tick and start in the same cycle in IDLE: the start transition wins; that tick is not counted in INTRO.
- Leaving FIGHT with busy=1 is impossible: end of round is only decided on a completion cycle.
- All outputs are registered. frame_step never asserts outside FIGHT.

Test Plan:
Bench parameters: MAX_HEALTH=30, HIT_DAMAGE=10, FRAMES_PER_SEC=4, ROUND_SECONDS=3, INTRO_FRAMES=2, OUTRO_FRAMES=2, ROUNDS_TO_WIN=2; model logic_done rising 3 cycles after frame_step.
- Reset then start, 2 ticks -> phase 0 to 1 to 2; logic_rst=1 through INTRO, 0 after; first FIGHT tick gives exactly one frame_step pulse.
- p1_hit on 3 consecutive completions -> p2_health 30, 20, 10, 0; ROUND_END with round_winner=01, p1_rounds=1; after 2 ticks phase=INTRO, healths=30.
- p1_hit and p2_hit together, 3 times -> both 0, draw: round_winner=00, rounds unchanged.
- No hits for 12 completed frames -> timer_sec 3, 2, 1, 0; timeout draw. Repeat with one p2_hit -> round_winner=10.
- Two P1 round wins -> MATCH_OVER, match_winner=01, no frame_step on further ticks; start -> INTRO, rounds=0.
- Hold logic_done=0 across 300 ticks -> one frame_step only, overrun_cnt saturates at 255. Assert rst=0 mid-FIGHT -> all reset values the same cycle.
